aes_inv_cipher_seq: RTL

AES_INV_CIPHER_SEQ -- requirements
Module: aes_inv_cipher_seq

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/aes_inv_round.sv | 50 +++++
 rtl/aes_inv_cipher_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES tables and helpers for the sequential inverse cipher.
// Holds the forward S-box (key schedule), the inverse S-box (rounds), the Rcon
// table, GF(2^8) xtime/multiply and the controller state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_KEXP  = 2'b01,
    ST_ARK0  = 2'b10,
    ST_ROUND = 2'b11
  } aes_state_e;

  // Entry b lives at bits [8*(255-b) +: 8], i.e. byte 0 is the leftmost.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Rcon[i] for i = 1..10; entries 0 and 11..15 are unused.
  localparam logic [127:0] RCON_TBL = 128'h00010204081020408_01b3600000000000 >> 4;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON_TBL[{~idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (enough for the 9/11/13/14 InvMixColumns factors).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on last_round).
// Ports:
//   state_in   [127:0]  round input, byte 0 in bits [127:120]
//   round_key  [127:0]  round key for this round
//   last_round          1 = final round, no InvMixColumns
//   state_out  [127:0]  round output
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] sr;
  logic [127:0] ark;
  logic [127:0] mc;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    sr  = '0;
    ark = '0;
    mc  = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    // Byte 4c+r is row r of column c; row r rotates right by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r)&3)+r) -: 8];
    for (int i = 0; i < 16; i++)
      ark[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]) ^ round_key[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      mc[127-32*c -: 8] = gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9);
      mc[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD);
      mc[111-32*c -: 8] = gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'hE) ^ gmul(a3, 4'hB);
      mc[103-32*c -: 8] = gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'hE);
    end
  end

  assign state_out = last_round ? ark : mc;

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Sequential AES-128/192/256 decryption: key schedule expanded one word per
// cycle, then one inverse round per cycle through a single aes_inv_round.
// Ports:
//   clk, rst (async, active high)
//   start            request, sampled while busy=0
//   data_in  [127:0] ciphertext, byte 0 in [127:120]
//   key_in   [Nk*32-1:0] cipher key, same byte order
//   busy             accept edge .. done edge
//   done             one-cycle pulse, data_out valid
//   data_out [127:0] plaintext, held until next done or reset
// Optional: define AES_INV_KEY_CACHE_EN to reuse the last expanded schedule
// when the same key arrives again (skips KEXP).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_KEXP  | generating key-schedule words Nk..4*(Nr+1)-1
// ST_ARK0  | state = ciphertext ^ round key Nr
// ST_ROUND | one inverse round per cycle, counter Nr-1 down to 0
module aes_inv_cipher_seq
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      data_in,
  input  logic [Nk*32-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic [127:0]      data_out
);

  localparam int         NW      = 4 * (Nr + 1);
  localparam int         WEXP    = NW - Nk;
  localparam logic [5:0] WEXP_M1 = 6'(WEXP - 1);
  localparam logic [5:0] NR_M1   = 6'(Nr - 1);

  aes_state_e   fsm_q, fsm_d;
  logic [5:0]   cnt_q;
  logic [2:0]   kmod_q;
  logic [3:0]   rcon_idx_q;
  logic [127:0] st_q;
  logic [31:0]  w_q [NW];
  logic         accept;
  logic         cache_hit;
  logic [5:0]   widx;
  logic [31:0]  w_prev, w_back, w_tmp, w_new;
  logic [3:0]   rk_sel;
  logic [5:0]   rk_base;
  logic [127:0] rk;
  logic [127:0] round_out;

  assign busy   = (fsm_q != ST_IDLE);
  assign accept = (fsm_q == ST_IDLE) && start;

`ifdef AES_INV_KEY_CACHE_EN
  // Words 0..Nk-1 of the schedule are the key that produced it.
  logic             cache_vld_q;
  logic [Nk*32-1:0] cached_key;
  for (genvar k = 0; k < Nk; k++) begin : g_ckey
    assign cached_key[(Nk-1-k)*32 +: 32] = w_q[k];
  end
  assign cache_hit = cache_vld_q && (key_in == cached_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cache_vld_q <= 1'b0;
    else if (accept)                         cache_vld_q <= cache_hit;
    else if (fsm_q == ST_KEXP && cnt_q == '0) cache_vld_q <= 1'b1;
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (start) fsm_d = cache_hit ? ST_ARK0 : ST_KEXP;
      ST_KEXP:  if (cnt_q == '0) fsm_d = ST_ARK0;
      ST_ARK0:  fsm_d = ST_ROUND;
      ST_ROUND: if (cnt_q == '0) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  // The KEXP down-counter doubles as the word index: Wexp-1 maps to word Nk.
  assign widx   = 6'(NW - 1) - cnt_q;
  assign w_prev = w_q[widx - 6'd1];
  assign w_back = w_q[widx - 6'(Nk)];

  always_comb begin
    w_tmp = w_prev;
    if (kmod_q == 3'd0)
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(rcon_idx_q), 24'h000000};
    else if (Nk > 6 && kmod_q == 3'd4)
      w_tmp = sub_word(w_prev);
    w_new = w_back ^ w_tmp;
  end

  assign rk_sel  = (fsm_q == ST_ARK0) ? 4'(Nr) : cnt_q[3:0];
  assign rk_base = {rk_sel, 2'b00};
  assign rk      = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};

  aes_inv_round u_round (
    .state_in   (st_q),
    .round_key  (rk),
    .last_round (cnt_q == '0),
    .state_out  (round_out)
  );

  // Schedule storage needs no reset; validity is tracked by the FSM/cache flag.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < Nk; k++) w_q[k] <= key_in[(Nk-1-k)*32 +: 32];
    end else if (fsm_q == ST_KEXP) begin
      w_q[widx] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      kmod_q     <= '0;
      rcon_idx_q <= 4'd1;
      st_q       <= '0;
      data_out   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        ST_IDLE: if (accept) begin
          st_q       <= data_in;
          cnt_q      <= WEXP_M1;
          kmod_q     <= '0;
          rcon_idx_q <= 4'd1;
        end
        ST_KEXP: begin
          cnt_q  <= cnt_q - 6'd1;
          kmod_q <= (kmod_q == 3'(Nk - 1)) ? 3'd0 : kmod_q + 3'd1;
          if (kmod_q == 3'd0) rcon_idx_q <= rcon_idx_q + 4'd1;
        end
        ST_ARK0: begin
          st_q  <= st_q ^ rk;
          cnt_q <= NR_M1;
        end
        ST_ROUND: begin
          st_q <= round_out;
          if (cnt_q == '0) begin
            data_out <= round_out;
            done     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
